// File: rtl/ycbcr2rgb_if.sv
// Pixel stream bundle for the YCbCr -> RGB converter: input and output
// valid/ready channels. clip_out exists only with YCC2RGB_CLIP_FLAG_EN.
interface ycbcr2rgb_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] data_out;
`ifdef YCC2RGB_CLIP_FLAG_EN
    logic [2:0]  clip_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, clip_out
    );
    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, clip_out
    );
`else
    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );
    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
`endif
endinterface

// File: rtl/ycbcr2rgb.sv
// Two-stage YCbCr (level-shifted, signed) to saturated RGB888 converter.
// Optional per-component clamp flags: define YCC2RGB_CLIP_FLAG_EN.
module ycbcr2rgb #(
    parameter int COEF_FRAC = 14
) (
    input  logic       clk,
    input  logic       rst,
    ycbcr2rgb_if.slave bus
);
    localparam int ACC_W = 26;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t KR  = acc_t'(22970);
    localparam acc_t KGB = acc_t'(5638);
    localparam acc_t KGR = acc_t'(11700);
    localparam acc_t KB  = acc_t'(29032);
    localparam acc_t RND = acc_t'(1) <<< (COEF_FRAC - 1);

    logic advance;
    logic accept;

    logic [7:0] yu;
    acc_t       cb_x, cr_x;
    acc_t       ysc_d, kr_d, kgb_d, kgr_d, kb_d;
    acc_t       ysc_q, kr_q, kgb_q, kgr_q, kb_q;
    logic       v1_q;

    acc_t        r_sum, g_sum, b_sum;
    acc_t        r_sh, g_sh, b_sh;
    logic [23:0] data_d, data_q;
    logic        out_valid_q;

    function automatic acc_t rnd_shift(input acc_t s);
        return (s + RND) >>> COEF_FRAC;
    endfunction

    function automatic logic [7:0] clamp8(input acc_t q);
        if (q[ACC_W-1])
            return 8'h00;
        else if (q > acc_t'(255))
            return 8'hFF;
        else
            return q[7:0];
    endfunction

    // The pipe only moves when the output register is free or draining.
    assign advance = !out_valid_q || bus.out_ready;
    assign accept  = bus.in_valid && advance;

    // Y+128 on a two's complement byte is just an MSB flip.
    always_comb begin
        yu    = {~bus.data_in[7], bus.data_in[6:0]};
        cb_x  = acc_t'($signed(bus.data_in[15:8]));
        cr_x  = acc_t'($signed(bus.data_in[23:16]));
        ysc_d = acc_t'(yu) <<< COEF_FRAC;
        kr_d  = KR * cr_x;
        kgb_d = KGB * cb_x;
        kgr_d = KGR * cr_x;
        kb_d  = KB * cb_x;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            ysc_q <= '0;
            kr_q  <= '0;
            kgb_q <= '0;
            kgr_q <= '0;
            kb_q  <= '0;
        end else if (advance) begin
            v1_q  <= accept;
            ysc_q <= ysc_d;
            kr_q  <= kr_d;
            kgb_q <= kgb_d;
            kgr_q <= kgr_d;
            kb_q  <= kb_d;
        end
    end

    always_comb begin
        r_sum  = ysc_q + kr_q;
        g_sum  = ysc_q - kgb_q - kgr_q;
        b_sum  = ysc_q + kb_q;
        r_sh   = rnd_shift(r_sum);
        g_sh   = rnd_shift(g_sum);
        b_sh   = rnd_shift(b_sum);
        data_d = {clamp8(b_sh), clamp8(g_sh), clamp8(r_sh)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
        end else if (advance) begin
            out_valid_q <= v1_q;
            data_q      <= data_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;

`ifdef YCC2RGB_CLIP_FLAG_EN
    logic [2:0] clip_d, clip_q;

    function automatic logic is_clip(input acc_t q);
        return q[ACC_W-1] || (q > acc_t'(255));
    endfunction

    always_comb begin
        clip_d = {is_clip(b_sh), is_clip(g_sh), is_clip(r_sh)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clip_q <= '0;
        else if (advance)
            clip_q <= clip_d;
    end

    assign bus.clip_out = clip_q;
`endif
endmodule

// File: tb/tb_ycbcr2rgb.sv
// Bench for ycbcr2rgb: directed vectors, backpressure, async reset and
// random traffic scored against an integer-arithmetic colour model.
module tb_ycbcr2rgb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ycbcr2rgb_if bus();

    ycbcr2rgb #(.COEF_FRAC(14)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    logic [26:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Returns {clipB, clipG, clipR, B, G, R}.
    function automatic logic [26:0] golden(input logic [23:0] d);
        int y, cb, cr, yu, r, g, b;
        logic [2:0] c;
        y  = int'($signed(d[7:0]));
        cb = int'($signed(d[15:8]));
        cr = int'($signed(d[23:16]));
        yu = y + 128;
        r  = (yu * 16384 + 22970 * cr + 8192) >>> 14;
        g  = (yu * 16384 - 5638 * cb - 11700 * cr + 8192) >>> 14;
        b  = (yu * 16384 + 29032 * cb + 8192) >>> 14;
        c  = {sat(b) != b, sat(g) != g, sat(r) != r};
        return {c, 8'(sat(b)), 8'(sat(g)), 8'(sat(r))};
    endfunction

    // Scoreboard / protocol monitor, sampling on the falling edge.
    initial begin
        logic        prev_stall;
        logic [23:0] prev_data;
        logic [26:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 1);
                    chk("stall_hold", 32'(bus.data_out), 32'(prev_data));
                end
                if (bus.out_valid && !bus.out_ready)
                    chk("stall_in_ready", 32'(bus.in_ready), 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h expected none",
                                 bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", 32'(bus.data_out), 32'(e[23:0]));
`ifdef YCC2RGB_CLIP_FLAG_EN
                        chk("clip_out", 32'(bus.clip_out), 32'(e[26:24]));
`endif
                        n_out++;
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(golden(bus.data_in));
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.data_out;
            end
        end
    end

    task automatic directed(input string name, input logic [23:0] d,
                            input logic [23:0] exp, input logic [2:0] expc);
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({name, "_early"}, 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 32'(bus.out_valid), 1);
        chk(name, 32'(bus.data_out), 32'(exp));
`ifdef YCC2RGB_CLIP_FLAG_EN
        chk({name, "_clip"}, 32'(bus.clip_out), 32'(expc));
`else
        if (expc == 3'b111) $display("note: unreachable clip pattern");
`endif
        @(posedge clk); #1;
    endtask

    logic [23:0] px [5] = '{24'h102030, 24'hF0E0D0, 24'h7F807F,
                            24'h00FF01, 24'hC3A511};

    initial begin
        int sent, stall_left, n0, fired, cyc;
        bit stall_done, fire;

        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
`ifdef YCC2RGB_CLIP_FLAG_EN
        chk("rst_clip", 32'(bus.clip_out), 0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        directed("grey",    24'h000000, 24'h808080, 3'b000);
        directed("white",   24'h00007F, 24'hFFFFFF, 3'b000);
        directed("black",   24'h000080, 24'h000000, 3'b000);
        directed("sat_r",   24'h7F007F, 24'hFFA4FF, 3'b001);
        directed("sat_b",   24'h008000, 24'h00AC80, 3'b100);

        // Backpressure: five pixels, output held off for three cycles.
        n0 = n_out;
        sent = 0;
        stall_left = 0;
        stall_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (sent < 5);
            bus.data_in  = (sent < 5) ? px[sent] : 24'h0;
            if (!stall_done && bus.out_valid) begin
                stall_left = 3;
                stall_done = 1'b1;
            end
            bus.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) sent++;
        end
        chk("bp_count", 32'(n_out - n0), 5);
        chk("bp_empty", 32'(exp_q.size()), 0);
        chk("bp_stalled", 32'(stall_done), 1);

        // Asynchronous reset with both stages occupied.
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = 24'($urandom);
            @(posedge clk); #1;
        end
        chk("pre_rst_full", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_data", 32'(bus.data_out), 0);
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(bus.out_valid), 0);

        // Random traffic: 10k accepted pixels.
        fired = 0;
        cyc = 0;
        bus.in_valid = 1'b0;
        while (fired < 10000 && cyc < 60000) begin
            if (!bus.in_valid || fire) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.data_in  = 24'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) fired++;
            cyc++;
        end
        chk("rand_fired", 32'(fired), 10000);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++)
            @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ycbcr2rgb.md
Name: ycbcr2rgb

Overview:
- Inverse colour-space converter for the JPEG decode path. Sits after the inverse DCT/level-shift stage and feeds the pixel output buffer.
- Accepts level-shifted signed Y, Cb, Cr (each -128..127) and produces saturated unsigned 8-bit R, G, B.
- Two-stage pipeline with valid/ready handshaking; the whole pipe stalls under downstream backpressure.

Parameters:
- COEF_FRAC, 14, fractional bits of the fixed-point coefficients (rounding constant is 2^(COEF_FRAC-1)).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in holds a valid pixel.
- in_ready  output  1  block accepts data_in this cycle.
- data_in  input  24  [7:0]=Y, [15:8]=Cb, [23:16]=Cr, all two's complement.
- out_valid  output  1  data_out holds a valid pixel.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  24  [7:0]=R, [15:8]=G, [23:16]=B, all unsigned.

Behaviour:
- Reset (rst low, asynchronous): stage-1 valid, out_valid, data_out and all product registers go to 0. On release, in_ready=1 combinationally from the empty pipe. A reset mid-operation discards all in-flight pixels with no output.
- Coefficients (Q14): KR=22970 (1.402), KGB=5638 (0.344136), KGR=11700 (0.714136), KB=29032 (1.772).
- Y is un-shifted before scaling: Yu = Y + 128 (0..255).
- Transfer: advance = !out_valid || out_ready. in_ready = advance. A pixel is accepted when in_valid && in_ready.
- Stage 1 (on advance):
  - register Yu<<14, KR*Cr, KGB*Cb, KGR*Cr and KB*Cb as signed products;
  - v1 <= accepted.
- Stage 2 (on advance):
  - R = Yu·2^14 + KR·Cr; G = Yu·2^14 − KGB·Cb − KGR·Cr; B = Yu·2^14 + KB·Cb.
  - Each sum is computed in a 26-bit signed accumulator, then +8192, then arithmetic shift right by 14.
  - Clamp results below 0 to 0 and above 255 to 255.
  - out_valid <= v1.
- Latency: 2 cycles from acceptance to out_valid when there is no backpressure. Throughput: 1 pixel/clk.
- Stall: when out_valid && !out_ready, all pipeline registers hold, in_ready=0, and data_out stays stable until it is consumed.
- Simultaneous in_valid and a stall: the input is not accepted, and the upstream block must hold data_in.
- Bubbles: a bubble (in_valid=0 on an advance) propagates as v1=0. Bubbles are not squeezed out while stalled.
- Timing: no combinational path from in_valid to out_valid or from data_in to data_out. in_ready depends combinationally only on out_ready and out_valid.

Optional Feature:
- Macro: YCC2RGB_CLIP_FLAG_EN.
- Defined:
  - adds output port clip_out [2:0], with bit0=R, bit1=G, bit2=B;
  - a bit is set when that component was clamped in stage 2;
  - it is registered alongside data_out, holds under stall, and is 0 on reset.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Mid-grey: out_ready=1, data_in=24'h000000 → two cycles later out_valid=1, data_out=24'h808080, clip_out=3'b000.
- Extremes: data_in=24'h00007F → 24'hFFFFFF. data_in=24'h000080 → 24'h000000, with no wrap.
- Saturation: data_in=24'h7F007F (Y=127, Cr=127) → data_out=24'hFFA4FF (R clamped, G=164, B=255); clip_out=3'b001.
  - data_in=24'h008000 (Y=0, Cb=-128) → data_out=24'h00AC80 (B clamped to 0, G=172, R=128); clip_out=3'b100.
- Backpressure: stream 5 distinct pixels and drop out_ready for 3 cycles while out_valid=1.
  - data_out stays stable and in_ready=0 during the stall.
  - All 5 outputs arrive in order with no loss or duplication.
- Reset mid-stream: assert rst low asynchronously (not on a clk edge) with both stages full.
  - out_valid and data_out go to 0 immediately.
  - After release, in_ready=1 and no stale pixel ever appears.
- Random: 10k random pixels with random in_valid/out_ready, compared to a golden model implementing the same fixed-point formula → exact match.
